vout_line_fetch_sched: RTL

- Schedules line-fetch commands for the multi-port video output path.
- Collects the per-port line requests (rdreq0..5 pulses plus line_number) from the display timing generator.
- Queues one pending fetch per port and grants ports round-robin to a single shared frame-read DMA through a valid/ready command channel.
- Waits for DMA completion, with a watchdog timeout, before issuing the next command.

---
 rtl/vout_pkg.sv | 21 ++
 rtl/vout_line_fetch_sched_rr_arbiter.sv | 34 +++
 rtl/vout_line_fetch_sched.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/vout_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vout_pkg
// Brief   : Shared defaults, FSM encoding and port-index type for the
//           video-output line fetch scheduler.
// Revision: 1.0
// ============================================================================
package vout_pkg;
    localparam int NUM_PORTS_DEF = 6;
    localparam int PORT_W_DEF    = 3;
    localparam int LINE_W_DEF    = 16;
    localparam int TIMEOUT_DEF   = 4095;
    localparam int TO_W_DEF      = 12;

    typedef logic [PORT_W_DEF-1:0] port_idx_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
endpackage
`default_nettype wire

// File: rtl/vout_line_fetch_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin picker; first request above 'last'.
// Revision: 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NUM_PORTS = 6,
    parameter int PORT_W    = 3
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    last,
    output logic [PORT_W-1:0]    gnt_idx,
    output logic                 gnt_vld
);
    // Walk offsets from farthest to nearest so the nearest hit overrides.
    always_comb begin
        int idx;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            idx = int'(last) + k;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (req[PORT_W'(idx)]) begin
                gnt_idx = PORT_W'(idx);
                gnt_vld = 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/vout_line_fetch_sched.sv
`default_nettype none
// ============================================================================
// Module  : vout_line_fetch_sched
// Brief   : Queues one line fetch per video port and issues them round-robin
//           to a shared frame-read DMA, one outstanding command at a time.
// Revision: 1.0
// ============================================================================
module vout_line_fetch_sched
    import vout_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int PORT_W    = PORT_W_DEF,
    parameter int LINE_W    = LINE_W_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF,
    parameter int TO_W      = TO_W_DEF
) (
    input  logic                 dp_clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] port_en,
    input  logic [NUM_PORTS-1:0] rdreq,
    input  logic [LINE_W-1:0]    line_number,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [PORT_W-1:0]    cmd_port,
    output logic [LINE_W-1:0]    cmd_line,
    input  logic                 fetch_done,
    output logic                 busy,
    output logic [NUM_PORTS-1:0] overflow,
    output logic                 timeout_err,
    input  logic                 err_clr
);
    logic [1:0]           state_q, state_d;
    logic [NUM_PORTS-1:0] pending_q, pending_d;
    logic [NUM_PORTS-1:0] overflow_q, overflow_d;
    logic [LINE_W-1:0]    line_q [NUM_PORTS];
    logic [LINE_W-1:0]    line_d [NUM_PORTS];
    logic [PORT_W-1:0]    grant_q, grant_d;
    logic [PORT_W-1:0]    last_grant_q, last_grant_d;
    logic [PORT_W-1:0]    cmd_port_q, cmd_port_d;
    logic [LINE_W-1:0]    cmd_line_q, cmd_line_d;
    logic                 cmd_valid_q, cmd_valid_d;
    logic                 timeout_err_q, timeout_err_d;
    logic [TO_W-1:0]      wd_cnt_q, wd_cnt_d;
    logic                 handshake;
    logic                 to_fire;
    logic [PORT_W-1:0]    arb_idx;
    logic                 arb_vld;

    assign handshake = cmd_valid_q & cmd_ready;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_arb (
        .req     (pending_q & port_en),
        .last    (last_grant_q),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    // A fresh request beats the handshake clear for the same port.
    always_comb begin
        pending_d  = pending_q;
        line_d     = line_q;
        overflow_d = err_clr ? '0 : overflow_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!port_en[i]) begin
                pending_d[i] = 1'b0;
            end else if (rdreq[i]) begin
                pending_d[i] = 1'b1;
                line_d[i]    = line_number;
                if (pending_q[i] && !(handshake && grant_q == PORT_W'(i))) begin
                    overflow_d[i] = 1'b1;
                end
            end else if (handshake && grant_q == PORT_W'(i)) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cmd_port_d   = cmd_port_q;
        cmd_line_d   = cmd_line_q;
        cmd_valid_d  = cmd_valid_q;
        wd_cnt_d     = wd_cnt_q;
        to_fire      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    grant_d     = arb_idx;
                    cmd_port_d  = arb_idx;
                    cmd_line_d  = line_q[arb_idx];
                    cmd_valid_d = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (handshake) begin
                    cmd_valid_d  = 1'b0;
                    last_grant_d = grant_q;
                    wd_cnt_d     = '0;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (fetch_done) begin
                    state_d = ST_IDLE;
                end else if (wd_cnt_q == TO_W'(TIMEOUT - 1)) begin
                    to_fire = 1'b1;
                    state_d = ST_IDLE;
                end else if (wd_cnt_q != '1) begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        timeout_err_d = (err_clr ? 1'b0 : timeout_err_q) | to_fire;
    end

    always_comb begin
        busy        = (state_q != ST_IDLE);
        cmd_valid   = cmd_valid_q;
        cmd_port    = cmd_port_q;
        cmd_line    = cmd_line_q;
        overflow    = overflow_q;
        timeout_err = timeout_err_q;
    end

    always_ff @(posedge dp_clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pending_q     <= '0;
            overflow_q    <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                line_q[i] <= '0;
            end
            grant_q       <= '0;
            last_grant_q  <= PORT_W'(NUM_PORTS - 1);
            cmd_port_q    <= '0;
            cmd_line_q    <= '0;
            cmd_valid_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            wd_cnt_q      <= '0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            overflow_q    <= overflow_d;
            line_q        <= line_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            cmd_port_q    <= cmd_port_d;
            cmd_line_q    <= cmd_line_d;
            cmd_valid_q   <= cmd_valid_d;
            timeout_err_q <= timeout_err_d;
            wd_cnt_q      <= wd_cnt_d;
        end
    end
endmodule
`default_nettype wire
